hazard_stall_unit: RTL

- Pipeline interlock controller for the 5-stage core.
- Handles the hazards that EX-stage forwarding cannot resolve: load-use dependences, taken-branch redirects, instruction/data memory wait cycles, and halt drain.
- Drives per-stage pipeline-register write enables and NOP-insertion controls.
- Keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/hazard_stall_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: load-use bubbles, taken-branch flushes, memory-wait freezes and halt drain.
// Latency: outputs are combinational from state and inputs; the state advances on each rising clk edge.
// Backpressure: imem/dmem wait freezes every pipeline register. HALTED ignores further waits until reset.
module hazard_stall_unit #(
    parameter int REG_ADDR_W   = 3,
    parameter int DRAIN_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_ADDR_W-1:0]  fd_Rs,
    input  logic [REG_ADDR_W-1:0]  fd_Rt,
    input  logic                   fd_rs_used,
    input  logic                   fd_rt_used,
    input  logic [REG_ADDR_W-1:0]  de_write_reg,
    input  logic                   de_reg_wr,
    input  logic                   de_mem_rd,
    input  logic                   de_halt,
    input  logic                   ex_br_taken,
    input  logic                   imem_stall,
    input  logic                   dmem_stall,
    output logic                   pc_wr_en,
    output logic                   fd_wr_en,
    output logic                   de_wr_en,
    output logic                   em_wr_en,
    output logic                   mw_wr_en,
    output logic                   fd_flush,
    output logic                   de_bubble,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [STALL_CNT_W-1:0] w_stall_nxt;
    logic                   w_freeze;
    logic                   w_load_use;
    logic                   w_stall_inc;

    assign w_freeze   = imem_stall | dmem_stall;
    assign w_load_use = de_mem_rd & de_reg_wr &
                        ((fd_rs_used & (fd_Rs == de_write_reg)) |
                         (fd_rt_used & (fd_Rt == de_write_reg)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stall_cnt <= w_stall_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                // A taken branch squashes the halt sitting alongside it.
                if (!w_freeze && !ex_br_taken && de_halt) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = DRAIN_INIT;
                end
            end
            S_DRAIN: begin
                if (!w_freeze) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    always_comb begin
        pc_wr_en  = 1'b0;
        fd_wr_en  = 1'b0;
        de_wr_en  = 1'b0;
        em_wr_en  = 1'b0;
        mw_wr_en  = 1'b0;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        halted    = 1'b0;
        if (!rst_n) begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!w_freeze) begin
                        pc_wr_en = 1'b1;
                        fd_wr_en = 1'b1;
                        de_wr_en = 1'b1;
                        em_wr_en = 1'b1;
                        mw_wr_en = 1'b1;
                        if (ex_br_taken) begin
                            fd_flush  = 1'b1;
                            de_bubble = 1'b1;
                        end else if (de_halt) begin
                            fd_flush = 1'b1;
                        end else if (w_load_use) begin
                            pc_wr_en  = 1'b0;
                            fd_wr_en  = 1'b0;
                            de_bubble = 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_freeze) begin
                        fd_wr_en  = 1'b1;
                        de_wr_en  = 1'b1;
                        em_wr_en  = 1'b1;
                        mw_wr_en  = 1'b1;
                        fd_flush  = 1'b1;
                        de_bubble = 1'b1;
                    end
                end
                S_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    // Any live cycle that does not advance the PC counts as a stall; HALTED is not live.
    assign w_stall_inc = (r_state != S_HALTED) && !pc_wr_en;
    assign w_stall_nxt = (w_stall_inc && !(&r_stall_cnt)) ? r_stall_cnt + 1'b1 : r_stall_cnt;

    assign stall_cycles = r_stall_cnt;

endmodule
